// File: rtl/alu_shift_pkg.sv
// Shared types and field layout for the ALU / iterative-shift request-response block.
package alu_shift_pkg;

  localparam int DATA_W = 32;
  localparam int REQ_W  = 68;
  localparam int RSP_W  = 34;
  localparam int CNT_W  = 5;

  // Shift-request field positions inside req_data
  localparam int REQ_DIR_BIT   = 37;
  localparam int REQ_SHAMT_LSB = 32;
  localparam int REQ_SFT_LSB   = 0;

  // Response field positions inside rsp_data
  localparam int RSP_OVF_BIT  = 33;
  localparam int RSP_ZERO_BIT = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    SHIFT = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_ADD = 2'b10,
    OP_SLT = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic              inv_a;
    logic              inv_b;
    alu_op_e           op;
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
  } alu_req_t;

  typedef struct packed {
    logic              ovf;
    logic              zero;
    logic [DATA_W-1:0] result;
  } rsp_t;

endpackage

// File: rtl/alu32_core.sv
// Combinational 32-bit ALU: AND / OR / ADD / SLT with optional operand inversion.
module alu32_core
  import alu_shift_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              invert_a,
  input  logic              invert_b,
  input  alu_op_e           operation,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              overflow
);

  logic [DATA_W-1:0] a_eff;
  logic [DATA_W-1:0] b_eff;
  logic [DATA_W-2:0] sum_low;
  logic              carry_in_31;
  logic              sum_31;
  logic              carry_out;
  logic              add_ovf;
  logic              set_lt;

  always_comb begin
    // NOTE: every output of this block gets a value on every path first, so no latch is inferred.
    result   = '0;
    overflow = 1'b0;

    a_eff = invert_a ? ~a : a;
    b_eff = invert_b ? ~b : b;

    // Split the add at bit 31 so both carries needed for signed overflow are visible.
    {carry_in_31, sum_low} = {1'b0, a_eff[DATA_W-2:0]} + {1'b0, b_eff[DATA_W-2:0]}
                           + {{(DATA_W-1){1'b0}}, invert_b};
    sum_31    = a_eff[DATA_W-1] ^ b_eff[DATA_W-1] ^ carry_in_31;
    carry_out = (a_eff[DATA_W-1] & b_eff[DATA_W-1]) |
                (a_eff[DATA_W-1] & carry_in_31)     |
                (b_eff[DATA_W-1] & carry_in_31);
    add_ovf   = carry_in_31 ^ carry_out;
    set_lt    = sum_31 ^ add_ovf;

    case (operation)
      OP_AND: result = a_eff & b_eff;
      OP_OR:  result = a_eff | b_eff;
      OP_ADD: begin
        result   = {sum_31, sum_low};
        overflow = add_ovf;
      end
      OP_SLT: begin
        result   = {{(DATA_W-1){1'b0}}, set_lt};
        overflow = add_ovf;
      end
    endcase

    zero = (result == '0);
  end

endmodule

// File: rtl/alu_shift_responder.sv
// Single-outstanding request/response engine: one-cycle ALU ops or bit-serial logical shifts.
module alu_shift_responder
  import alu_shift_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_kind,
  input  logic [REQ_W-1:0] req_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_kind,
  output logic [RSP_W-1:0] rsp_data
);

  state_e            state_q,     state_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_kind_q,  rsp_kind_d;
  rsp_t              rsp_data_q,  rsp_data_d;
  logic [DATA_W-1:0] src_a_q,     src_a_d;
  logic [DATA_W-1:0] opnd_q,      opnd_d;
  logic              inv_a_q,     inv_a_d;
  logic              inv_b_q,     inv_b_d;
  alu_op_e           op_q,        op_d;
  logic              dir_q,       dir_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;

  alu_req_t          alu_req;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic              alu_ovf;

  assign alu_req = alu_req_t'(req_data);

  // The ALU sees only captured operands, so req_data may change freely after accept.
  alu32_core u_alu (
    .a         (src_a_q),
    .b         (opnd_q),
    .invert_a  (inv_a_q),
    .invert_b  (inv_b_q),
    .operation (op_q),
    .result    (alu_result),
    .zero      (alu_zero),
    .overflow  (alu_ovf)
  );

  always_comb begin
    state_d    = state_q;
    rsp_kind_d = rsp_kind_q;
    rsp_data_d = rsp_data_q;
    src_a_d    = src_a_q;
    opnd_d     = opnd_q;
    inv_a_d    = inv_a_q;
    inv_b_d    = inv_b_q;
    op_d       = op_q;
    dir_d      = dir_q;
    cnt_d      = cnt_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_kind) begin
            state_d = SHIFT;
            opnd_d  = req_data[REQ_SFT_LSB +: DATA_W];
            cnt_d   = req_data[REQ_SHAMT_LSB +: CNT_W];
            dir_d   = req_data[REQ_DIR_BIT];
          end else begin
            state_d = EXEC;
            src_a_d = alu_req.src1;
            opnd_d  = alu_req.src2;
            inv_a_d = alu_req.inv_a;
            inv_b_d = alu_req.inv_b;
            op_d    = alu_req.op;
          end
        end
      end
      EXEC: begin
        state_d    = RESP;
        rsp_kind_d = 1'b0;
        rsp_data_d = '{ovf: alu_ovf, zero: alu_zero, result: alu_result};
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          opnd_d = dir_q ? (opnd_q << 1) : (opnd_q >> 1);
          cnt_d  = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          state_d    = RESP;
          rsp_kind_d = 1'b1;
          rsp_data_d = '{ovf: 1'b0, zero: 1'b0, result: opnd_q};
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
    endcase

    // Handshake outputs are registered from the next state so they change with it.
    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_kind_q  <= 1'b0;
      rsp_data_q  <= '0;
      src_a_q     <= '0;
      opnd_q      <= '0;
      inv_a_q     <= 1'b0;
      inv_b_q     <= 1'b0;
      op_q        <= OP_AND;
      dir_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_kind_q  <= rsp_kind_d;
      rsp_data_q  <= rsp_data_d;
      src_a_q     <= src_a_d;
      opnd_q      <= opnd_d;
      inv_a_q     <= inv_a_d;
      inv_b_q     <= inv_b_d;
      op_q        <= op_d;
      dir_q       <= dir_d;
      cnt_q       <= cnt_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_kind  = rsp_kind_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_alu_shift_responder.sv
// Directed self-checking bench for alu_shift_responder with hand-computed expected responses.
module tb_alu_shift_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_kind = 1'b0;
  logic [67:0] req_data = '0;
  logic        rsp_ready = 1'b0;
  logic        req_ready;
  logic        rsp_valid;
  logic        rsp_kind;
  logic [33:0] rsp_data;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_shift_responder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_kind  (req_kind),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_kind  (rsp_kind),
    .rsp_data  (rsp_data)
  );

  task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [67:0] alu_req(input logic ia, input logic ib, input logic [1:0] op,
                                          input logic [31:0] s1, input logic [31:0] s2);
    return {ia, ib, op, s1, s2};
  endfunction

  // Upper unused bits are filled with a pattern that must be ignored.
  function automatic logic [67:0] sft_req(input logic lr, input logic [4:0] sh, input logic [31:0] src);
    return {30'h2AAAAAAA, lr, sh, src};
  endfunction

  // Present one request, then count edges from the accept edge until rsp_valid is seen.
  task automatic send(input logic kind, input logic [67:0] data, input string tag,
                      output int lat, output logic ready_leak);
    @(negedge clk);
    check({tag, "_req_ready"}, {33'b0, req_ready}, 34'd1);
    req_valid = 1'b1;
    req_kind  = kind;
    req_data  = data;
    @(posedge clk);
    @(negedge clk);
    req_valid  = 1'b0;
    req_kind   = 1'b0;
    req_data   = '0;
    ready_leak = req_ready;
    lat = 0;
    while (lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (rsp_valid) break;
      if (req_ready) ready_leak = 1'b1;
    end
  endtask

  task automatic txn(input logic kind, input logic [67:0] data, input logic [33:0] exp_data,
                     input int exp_lat, input string tag);
    int   lat;
    logic leak;
    send(kind, data, tag, lat, leak);
    check({tag, "_latency"}, 34'(lat), 34'(exp_lat));
    check({tag, "_busy_ready"}, {33'b0, leak}, 34'd0);
    check({tag, "_data"}, rsp_data, exp_data);
    check({tag, "_kind"}, {33'b0, rsp_kind}, {33'b0, kind});
  endtask

  task automatic release_rsp(input string tag);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, "_rel_valid"}, {33'b0, rsp_valid}, 34'd0);
    check({tag, "_rel_ready"}, {33'b0, req_ready}, 34'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   lat;
    logic leak;
    logic seen;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_rsp_valid", {33'b0, rsp_valid}, 34'd0);
    check("reset_rsp_data", rsp_data, 34'd0);
    check("reset_rsp_kind", {33'b0, rsp_kind}, 34'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_req_ready", {33'b0, req_ready}, 34'd1);

    // ALU operations
    txn(1'b0, alu_req(0, 0, 2'b10, 32'h7FFFFFFF, 32'h00000001), 34'h2_8000_0000, 1, "add_ovf");
    release_rsp("add_ovf");
    txn(1'b0, alu_req(0, 1, 2'b10, 32'h12345678, 32'h12345678), 34'h1_0000_0000, 1, "sub_zero");
    release_rsp("sub_zero");
    txn(1'b0, alu_req(1, 1, 2'b00, 32'h00000000, 32'h00000000), 34'h0_FFFF_FFFF, 1, "nor");
    release_rsp("nor");
    txn(1'b0, alu_req(0, 1, 2'b11, 32'hFFFFFFFF, 32'h00000001), 34'h0_0000_0001, 1, "slt_neg");
    release_rsp("slt_neg");
    txn(1'b0, alu_req(0, 1, 2'b11, 32'h80000000, 32'h00000001), 34'h2_0000_0001, 1, "slt_ovf");
    release_rsp("slt_ovf");
    txn(1'b0, alu_req(0, 1, 2'b11, 32'h00000005, 32'h00000001), 34'h1_0000_0000, 1, "slt_clear");
    release_rsp("slt_clear");
    txn(1'b0, alu_req(0, 0, 2'b00, 32'hF0F0F0F0, 32'hFF00FF00), 34'h0_F000_F000, 1, "and");
    release_rsp("and");
    txn(1'b0, alu_req(0, 0, 2'b01, 32'hF0F0F0F0, 32'hFF00FF00), 34'h0_FFF0_FFF0, 1, "or");
    release_rsp("or");
    txn(1'b0, alu_req(0, 0, 2'b10, 32'hFFFFFFFF, 32'h00000001), 34'h1_0000_0000, 1, "add_wrap");
    release_rsp("add_wrap");

    // Shifts
    txn(1'b1, sft_req(1, 5'd31, 32'h00000001), 34'h0_8000_0000, 32, "shl31");
    release_rsp("shl31");
    txn(1'b1, sft_req(0, 5'd4, 32'h000000F0), 34'h0_0000_000F, 5, "shr4");
    release_rsp("shr4");
    txn(1'b1, sft_req(1, 5'd0, 32'hDEADBEEF), 34'h0_DEAD_BEEF, 1, "sh0");
    release_rsp("sh0");
    txn(1'b1, sft_req(1, 5'd8, 32'h80000001), 34'h0_0000_0100, 9, "shl8_drop");
    release_rsp("shl8_drop");

    // Back-pressure: hold in RESP while a competing request is presented
    txn(1'b0, alu_req(0, 0, 2'b01, 32'h0000A5A5, 32'h5A5A0000), 34'h0_5A5A_A5A5, 1, "hold");
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1;
      req_kind  = 1'b1;
      req_data  = sft_req(1, 5'd1, 32'h00000003);
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", {33'b0, rsp_valid}, 34'd1);
      check("hold_data", rsp_data, 34'h0_5A5A_A5A5);
      check("hold_kind", {33'b0, rsp_kind}, 34'd0);
      check("hold_req_ready", {33'b0, req_ready}, 34'd0);
    end
    release_rsp("hold");
    req_valid = 1'b0;
    req_kind  = 1'b0;
    req_data  = '0;
    txn(1'b1, sft_req(0, 5'd2, 32'h0000000C), 34'h0_0000_0003, 3, "after_hold");
    release_rsp("after_hold");

    // Leave a non-zero response in the register, then reset mid-shift
    txn(1'b0, alu_req(0, 0, 2'b10, 32'h00000010, 32'h00000020), 34'h0_0000_0030, 1, "pre_rst");
    release_rsp("pre_rst");
    @(negedge clk);
    req_valid = 1'b1;
    req_kind  = 1'b1;
    req_data  = sft_req(1, 5'd20, 32'h00000001);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_kind  = 1'b0;
    req_data  = '0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", {33'b0, rsp_valid}, 34'd0);
    check("rst_mid_data", rsp_data, 34'd0);
    check("rst_mid_kind", {33'b0, rsp_kind}, 34'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_rel_ready", {33'b0, req_ready}, 34'd1);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check("rst_no_stale", {33'b0, seen}, 34'd0);

    // Operation after reset recovery
    send(1'b0, alu_req(1, 0, 2'b00, 32'h0F0F0F0F, 32'hFFFFFFFF), "post_rst", lat, leak);
    check("post_rst_latency", 34'(lat), 34'd1);
    check("post_rst_data", rsp_data, 34'h0_F0F0_F0F0);
    release_rsp("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_shift_responder.md
ALU_SHIFT_RESPONDER -- requirements
Module: alu_shift_responder

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 Parameter: none; widths SHALL be fixed (data 32, request 68, response 34).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  block accepts request; high only in IDLE.
REQ-007 req_kind  input  1  0 = ALU request, 1 = shift request.
REQ-008 req_data  input  68  ALU: [67] invertA, [66] invertB, [65:64] operation, [63:32] src1, [31:0] src2; shift: [37] leftRight, [36:32] shamt, [31:0] sftSrc; unused bits ignored.
REQ-009 rsp_valid  output  1  response present.
REQ-010 rsp_ready  input  1  consumer accepts response.
REQ-011 rsp_kind  output  1  kind of the request that produced the response.
REQ-012 rsp_data  output  34  [33] overflow, [32] zero, [31:0] result.

Function
REQ-013 The FSM SHALL have states IDLE, EXEC, SHIFT, RESP.
REQ-014 Request transfer SHALL occur on a rising edge with req_valid=1 and req_ready=1; operands and kind SHALL be captured at that edge.
REQ-015 On accept: ALU kind -> EXEC; shift kind -> SHIFT with operand register = sftSrc and counter = shamt.
REQ-016 ALU operand A SHALL be src1 or ~src1 per invertA; operand B src2 or ~src2 per invertB; adder carry-in SHALL equal invertB.
REQ-017 operation 00 -> A&B; 01 -> A|B; 10 -> A+B+cin (mod 2^32); 11 -> {31'b0, set}, set = sum[31] XOR overflow.
REQ-018 overflow SHALL be carry-into-bit-31 XOR carry-out-of-bit-31 for operations 10 and 11, and 0 for 00 and 01.
REQ-019 zero SHALL be 1 iff the 32-bit result is 0 (ALU kind only).
REQ-020 EXEC SHALL register the ALU response and go to RESP on the next edge: rsp_valid asserts exactly 1 cycle after the accept edge.
REQ-021 In SHIFT, each edge with counter != 0 SHALL shift the operand one bit logically (leftRight=1 left, 0 right, zero fill) and decrement the counter; an edge with counter == 0 SHALL go to RESP.
REQ-022 Shift latency SHALL be 1+shamt cycles from accept to rsp_valid (shamt=0 -> 1 cycle, shamt=31 -> 32 cycles).
REQ-023 Shift responses SHALL have rsp_data[33:32] = 2'b00.
REQ-024 In RESP, rsp_valid=1 and rsp_data/rsp_kind SHALL hold stable until an edge with rsp_ready=1, which returns to IDLE.
REQ-025 req_ready SHALL be 0 in EXEC, SHIFT and RESP; no request SHALL be accepted on the response-transfer edge (minimum 1 idle cycle between transactions).
REQ-026 rsp_valid SHALL be 0 in all states except RESP.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, rsp_valid=0, rsp_data=0, rsp_kind=0, counter=0, req_ready=1 after release, including mid-EXEC/SHIFT/RESP, with the in-flight transaction discarded.

Structure
REQ-028 A shared package alu_shift_pkg SHALL hold the state enum, operation-code constants (AND/OR/ADD/SLT) and request/response field positions.
REQ-029 Combinational ALU logic SHALL be a sub-module alu32_core (A, B, invertA, invertB, operation -> result, zero, overflow); the iterative shifter stays in the top level.

Verification
REQ-030 ALU op=10, inv=00, A=0x7FFFFFFF, B=1 -> rsp_data={1,0,0x80000000}, rsp_valid 1 cycle after accept.
REQ-031 ALU op=10, invB=1, A=B=0x12345678 -> result 0, zero=1, overflow=0; invA=invB=1 op=00, A=B=0 -> result 0xFFFFFFFF (NOR).
REQ-032 ALU op=11, invB=1, A=0xFFFFFFFF, B=1 -> result 1; A=0x80000000, B=1 -> result 1, overflow=1.
REQ-033 Shift leftRight=1, shamt=31, sftSrc=1 -> result 0x80000000 after exactly 32 cycles, req_ready=0 throughout; leftRight=0, shamt=4, 0xF0 -> 0x0F after 5 cycles.
REQ-034 rsp_ready held 0 for 5 cycles in RESP -> rsp_data/rsp_kind stable, req_ready=0; rsp_ready=1 -> IDLE next cycle, next request accepted.
REQ-035 rst_n pulsed low 3 cycles into a shamt=20 shift -> rsp_valid=0, rsp_data=0 immediately, req_ready=1 after release, no stale response.
